// File: rtl/mem_data_arb_pkg.sv
// Shared constants for the data-memory arbiter: requester-count limits and
// the lock-feature default, which follows the MEM_ARB_LOCK_EN build macro.
package processor_pkg;

    localparam int NREQ_MIN = 2;
    localparam int NREQ_MAX = 8;

`ifdef MEM_ARB_LOCK_EN
    localparam bit LOCK_EN_DEFAULT = 1'b1;
`else
    localparam bit LOCK_EN_DEFAULT = 1'b0;
`endif

endpackage

// File: rtl/mem_data_arb_if.sv
// Requester and memory-side bus of mem_data_arb; the arbiter is the slave.
// The lock vector exists only when MEM_ARB_LOCK_EN is defined.
interface mem_data_arb_if #(
    parameter int NREQ   = 2,
    parameter int MDATAW = 6,
    parameter int NUBITS = 16
);
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        we;
    logic [NREQ*MDATAW-1:0] addr;
    logic [NREQ*NUBITS-1:0] wdata;
`ifdef MEM_ARB_LOCK_EN
    logic [NREQ-1:0]        lock;
`endif
    logic [NREQ-1:0]        gnt;
    logic [NREQ-1:0]        rvalid;
    logic [NUBITS-1:0]      rdata;
    logic                   mem_wr;
    logic [MDATAW-1:0]      mem_addr_w;
    logic [MDATAW-1:0]      mem_addr_r;
    logic [NUBITS-1:0]      mem_data_in;
    logic [NUBITS-1:0]      mem_data_out;

`ifdef MEM_ARB_LOCK_EN
    modport slave (
        input  req, we, addr, wdata, lock, mem_data_out,
        output gnt, rvalid, rdata, mem_wr, mem_addr_w, mem_addr_r, mem_data_in
    );
    modport master (
        output req, we, addr, wdata, lock, mem_data_out,
        input  gnt, rvalid, rdata, mem_wr, mem_addr_w, mem_addr_r, mem_data_in
    );
`else
    modport slave (
        input  req, we, addr, wdata, mem_data_out,
        output gnt, rvalid, rdata, mem_wr, mem_addr_w, mem_addr_r, mem_data_in
    );
    modport master (
        output req, we, addr, wdata, mem_data_out,
        input  gnt, rvalid, rdata, mem_wr, mem_addr_w, mem_addr_r, mem_data_in
    );
`endif

endinterface

// File: rtl/mem_data_arb_rr_pick.sv
// Wrap-around priority search: first set req bit at or after ptr wins,
// wrapping from NREQ-1 back to 0. Output is one-hot or zero.
module rr_pick
    import processor_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PTRW = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PTRW-1:0] ptr,
    output logic [NREQ-1:0] gnt
);
    int   idx;
    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_data_arb.sv
// Round-robin arbiter sharing one registered data-memory port among NREQ
// requesters. Define MEM_ARB_LOCK_EN to add a per-requester lock input.
module mem_data_arb
    import processor_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int MDATAW = 6,
    parameter int NUBITS = 16
) (
    input logic           clk,
    input logic           rst,
    mem_data_arb_if.slave arb_if
);
    localparam int PTRW = $clog2(NREQ);

    if (NREQ < NREQ_MIN || NREQ > NREQ_MAX) begin : g_nreq_range
        $error("mem_data_arb: NREQ outside supported range");
    end

    logic [PTRW-1:0]   ptr_q, ptr_d;
    logic [PTRW-1:0]   gidx;
    logic [NREQ-1:0]   rr_gnt, hold_gnt, gnt_c;
    logic [NREQ-1:0]   rvalid_q, rvalid_d;
    logic              any_gnt, lock_hold;
    logic [MDATAW-1:0] addr_g;
    logic [NUBITS-1:0] wdata_g;

    rr_pick #(.NREQ(NREQ), .PTRW(PTRW)) u_rr_pick (
        .req (arb_if.req),
        .ptr (ptr_q),
        .gnt (rr_gnt)
    );

`ifdef MEM_ARB_LOCK_EN
    logic            lock_vld_q, lock_vld_d;
    logic [PTRW-1:0] lock_own_q, lock_own_d;

    // Ownership persists only while the last grantee keeps both req and lock up.
    assign lock_hold = LOCK_EN_DEFAULT && lock_vld_q
                       && arb_if.req[lock_own_q] && arb_if.lock[lock_own_q];
    assign hold_gnt  = NREQ'(1) << lock_own_q;

    always_comb begin
        lock_vld_d = any_gnt && arb_if.lock[gidx];
        lock_own_d = gidx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_vld_q <= 1'b0;
            lock_own_q <= '0;
        end else begin
            lock_vld_q <= lock_vld_d;
            lock_own_q <= lock_own_d;
        end
    end
`else
    assign lock_hold = LOCK_EN_DEFAULT;
    assign hold_gnt  = '0;
`endif

    always_comb begin
        gnt_c = lock_hold ? hold_gnt : rr_gnt;
        if (!rst) gnt_c = '0;
        any_gnt = |gnt_c;
        gidx    = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_c[i]) gidx = PTRW'(i);
        end
        addr_g  = arb_if.addr[gidx*MDATAW +: MDATAW];
        wdata_g = arb_if.wdata[gidx*NUBITS +: NUBITS];
        ptr_d   = ptr_q;
        if (any_gnt && !lock_hold) begin
            ptr_d = (gidx == PTRW'(NREQ - 1)) ? '0 : gidx + PTRW'(1);
        end
        rvalid_d = '0;
        if (any_gnt && !arb_if.we[gidx]) rvalid_d[gidx] = 1'b1;
    end

    // Read data returns one cycle after the grant, matching the memory latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q    <= '0;
            rvalid_q <= '0;
        end else begin
            ptr_q    <= ptr_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign arb_if.gnt         = gnt_c;
    assign arb_if.mem_wr      = any_gnt & arb_if.we[gidx];
    assign arb_if.mem_addr_w  = addr_g;
    assign arb_if.mem_addr_r  = addr_g;
    assign arb_if.mem_data_in = wdata_g;
    assign arb_if.rvalid      = rvalid_q;
    assign arb_if.rdata       = arb_if.mem_data_out;

endmodule

// File: tb/tb_mem_data_arb.sv
// Self-checking bench for mem_data_arb with a registered memory model and a
// behavioural round-robin reference; the lock scenario runs when MEM_ARB_LOCK_EN is set.
module tb_mem_data_arb;
    localparam int NREQ   = 2;
    localparam int MDATAW = 6;
    localparam int NUBITS = 16;
    localparam int DEPTH  = 64;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;

    mem_data_arb_if #(.NREQ(NREQ), .MDATAW(MDATAW), .NUBITS(NUBITS)) bus ();

    mem_data_arb #(.NREQ(NREQ), .MDATAW(MDATAW), .NUBITS(NUBITS)) dut (
        .clk    (clk),
        .rst    (rst),
        .arb_if (bus)
    );

    always #5 clk = ~clk;

    // Registered memory with one-cycle read latency; preload image applied in one edge.
    logic [NUBITS-1:0] mem     [DEPTH];
    logic [NUBITS-1:0] pre_img [DEPTH];
    logic              pre_en = 1'b0;
    always @(posedge clk) begin
        if (pre_en) for (int i = 0; i < DEPTH; i++) mem[i] <= pre_img[i];
        if (bus.mem_wr) mem[bus.mem_addr_w] <= bus.mem_data_in;
        bus.mem_data_out <= mem[bus.mem_addr_r];
    end

    // Reference state: next priority index, memory contents, expected read return.
    int                m_ptr;
    logic [NUBITS-1:0] m_mem [DEPTH];
    logic [NREQ-1:0]   m_rv;
    logic [NUBITS-1:0] m_rd;

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    task automatic model_step(input int g);
        int a;
        m_rv = '0;
        if (g >= 0) begin
            a = int'(bus.addr[g*MDATAW +: MDATAW]);
            if (bus.we[g]) m_mem[a] = bus.wdata[g*NUBITS +: NUBITS];
            else begin
                m_rv[g] = 1'b1;
                m_rd    = m_mem[a];
            end
            m_ptr = (g + 1) % NREQ;
        end
    endtask

    task automatic drive(input logic [1:0] r, input logic [1:0] w,
                         input logic [5:0] a0, input logic [5:0] a1,
                         input logic [15:0] d0, input logic [15:0] d1);
        bus.req   = r;
        bus.we    = w;
        bus.addr  = {a1, a0};
        bus.wdata = {d1, d0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mem();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = pre_img[i];
        pre_en = 1'b1;
        tick();
        pre_en = 1'b0;
    endtask

    task automatic apply_reset();
        drive(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
`ifdef MEM_ARB_LOCK_EN
        bus.lock = '0;
`endif
        rst = 1'b0;
        tick();
        rst = 1'b1;
        m_ptr = 0;
        m_rv  = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive(2'b11, 2'b11, 6'd1, 6'd2, 16'hAAAA, 16'h5555);
        @(negedge clk);
        n_chk++; if (bus.gnt !== 2'b00) $display("FAIL reset_gnt got=%b exp=00", bus.gnt); else n_pass++;
        n_chk++; if (bus.mem_wr !== 1'b0) $display("FAIL reset_mem_wr got=%b exp=0", bus.mem_wr); else n_pass++;
        n_chk++; if (bus.rvalid !== 2'b00) $display("FAIL reset_rvalid got=%b exp=00", bus.rvalid); else n_pass++;
        tick();
        rst = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.gnt !== 2'b01) $display("FAIL reset_first_gnt got=%b exp=01", bus.gnt); else n_pass++;
        tick();
        drive(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
    endtask

    task automatic test_contention();
        logic [1:0] eg;
        apply_reset();
        drive(2'b11, 2'b11, 6'd10, 6'd20, 16'h1111, 16'h2222);
        for (int c = 0; c < 4; c++) begin
            eg = (c % 2 == 0) ? 2'b01 : 2'b10;
            @(negedge clk);
            n_chk++; if (bus.gnt !== eg) $display("FAIL cont_gnt[%0d] got=%b exp=%b", c, bus.gnt, eg); else n_pass++;
            n_chk++; if (bus.mem_wr !== 1'b1) $display("FAIL cont_wr[%0d] got=%b exp=1", c, bus.mem_wr); else n_pass++;
            n_chk++; if (bus.mem_addr_w !== ((c % 2 == 0) ? 6'd10 : 6'd20))
                $display("FAIL cont_addr[%0d] got=%0d exp=%0d", c, bus.mem_addr_w, (c % 2 == 0) ? 10 : 20); else n_pass++;
            n_chk++; if (bus.mem_data_in !== ((c % 2 == 0) ? 16'h1111 : 16'h2222))
                $display("FAIL cont_data[%0d] got=%h", c, bus.mem_data_in); else n_pass++;
            tick();
        end
        drive(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
    endtask

    task automatic test_read_latency();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) pre_img[i] = 16'h0;
        pre_img[5] = 16'h1234;
        load_mem();
        drive(2'b10, 2'b00, 6'd0, 6'd5, 16'h0, 16'h0);
        @(negedge clk);
        n_chk++; if (bus.gnt !== 2'b10) $display("FAIL rdlat_gnt got=%b exp=10", bus.gnt); else n_pass++;
        n_chk++; if (bus.mem_addr_r !== 6'd5) $display("FAIL rdlat_addr got=%0d exp=5", bus.mem_addr_r); else n_pass++;
        n_chk++; if (bus.mem_wr !== 1'b0) $display("FAIL rdlat_wr got=%b exp=0", bus.mem_wr); else n_pass++;
        n_chk++; if (bus.rvalid !== 2'b00) $display("FAIL rdlat_early got=%b exp=00", bus.rvalid); else n_pass++;
        tick();
        drive(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
        @(negedge clk);
        n_chk++; if (bus.rvalid !== 2'b10) $display("FAIL rdlat_rvalid got=%b exp=10", bus.rvalid); else n_pass++;
        n_chk++; if (bus.rdata !== 16'h1234) $display("FAIL rdlat_rdata got=%h exp=1234", bus.rdata); else n_pass++;
        tick();
        @(negedge clk);
        n_chk++; if (bus.rvalid !== 2'b00) $display("FAIL rdlat_after got=%b exp=00", bus.rvalid); else n_pass++;
        tick();
    endtask

    task automatic test_write_then_read();
        apply_reset();
        for (int i = 0; i < DEPTH; i++) pre_img[i] = 16'h0;
        load_mem();
        drive(2'b01, 2'b01, 6'd3, 6'd0, 16'hBEEF, 16'h0);
        @(negedge clk);
        n_chk++; if (bus.gnt !== 2'b01) $display("FAIL wtr_wgnt got=%b exp=01", bus.gnt); else n_pass++;
        tick();
        drive(2'b10, 2'b00, 6'd0, 6'd3, 16'h0, 16'h0);
        @(negedge clk);
        n_chk++; if (bus.gnt !== 2'b10) $display("FAIL wtr_rgnt got=%b exp=10", bus.gnt); else n_pass++;
        tick();
        drive(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
        @(negedge clk);
        n_chk++; if (bus.rvalid !== 2'b10) $display("FAIL wtr_rvalid got=%b exp=10", bus.rvalid); else n_pass++;
        n_chk++; if (bus.rdata !== 16'hBEEF) $display("FAIL wtr_rdata got=%h exp=beef", bus.rdata); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_read();
        apply_reset();
        drive(2'b01, 2'b00, 6'd7, 6'd0, 16'h0, 16'h0);
        @(negedge clk);
        n_chk++; if (bus.gnt !== 2'b01) $display("FAIL midrst_gnt got=%b exp=01", bus.gnt); else n_pass++;
        tick();
        rst = 1'b0;
        drive(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
        @(negedge clk);
        n_chk++; if (bus.rvalid !== 2'b00) $display("FAIL midrst_in got=%b exp=00", bus.rvalid); else n_pass++;
        tick();
        rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_chk++; if (bus.rvalid !== 2'b00) $display("FAIL midrst_post[%0d] got=%b exp=00", c, bus.rvalid); else n_pass++;
            tick();
        end
        drive(2'b11, 2'b11, 6'd0, 6'd1, 16'h0, 16'h0);
        @(negedge clk);
        n_chk++; if (bus.gnt !== 2'b01) $display("FAIL midrst_resume got=%b exp=01", bus.gnt); else n_pass++;
        tick();
        drive(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
    endtask

    task automatic test_idle();
        apply_reset();
        drive(2'b01, 2'b01, 6'd9, 6'd0, 16'h7, 16'h0);
        tick();
        drive(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
        @(negedge clk);
        n_chk++; if (bus.gnt !== 2'b00) $display("FAIL idle_gnt got=%b exp=00", bus.gnt); else n_pass++;
        n_chk++; if (bus.mem_wr !== 1'b0) $display("FAIL idle_wr got=%b exp=0", bus.mem_wr); else n_pass++;
        tick();
        drive(2'b11, 2'b11, 6'd0, 6'd1, 16'h0, 16'h0);
        @(negedge clk);
        n_chk++; if (bus.rvalid !== 2'b00) $display("FAIL idle_rvalid got=%b exp=00", bus.rvalid); else n_pass++;
        n_chk++; if (bus.gnt !== 2'b10) $display("FAIL idle_ptr_hold got=%b exp=10", bus.gnt); else n_pass++;
        tick();
        drive(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
    endtask

    task automatic test_back_to_back();
        int g;
        logic [NREQ-1:0] eg;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) pre_img[i] = 16'($urandom);
        load_mem();
        for (int c = 0; c < 8; c++) begin
            drive(2'b11, 2'b00, 6'($urandom), 6'($urandom), 16'h0, 16'h0);
            @(negedge clk);
            g  = pick(bus.req, m_ptr);
            eg = '0;
            if (g >= 0) eg[g] = 1'b1;
            n_chk++; if (bus.gnt !== eg) $display("FAIL b2b_gnt[%0d] got=%b exp=%b", c, bus.gnt, eg); else n_pass++;
            n_chk++; if (bus.rvalid !== m_rv) $display("FAIL b2b_rvalid[%0d] got=%b exp=%b", c, bus.rvalid, m_rv); else n_pass++;
            if (m_rv != '0) begin
                n_chk++; if (bus.rdata !== m_rd) $display("FAIL b2b_rdata[%0d] got=%h exp=%h", c, bus.rdata, m_rd); else n_pass++;
            end
            model_step(g);
            tick();
        end
        drive(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
    endtask

    task automatic test_random();
        logic [NREQ-1:0]   pend, wv, eg;
        logic [MDATAW-1:0] av [NREQ];
        logic [NUBITS-1:0] dv [NREQ];
        int                waitc [NREQ];
        int                g;
        apply_reset();
        for (int i = 0; i < DEPTH; i++) pre_img[i] = 16'($urandom);
        load_mem();
        pend = '0;
        wv   = '0;
        for (int i = 0; i < NREQ; i++) begin
            waitc[i] = 0;
            av[i]    = '0;
            dv[i]    = '0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i] = 1'b1;
                    wv[i]   = 1'($urandom);
                    av[i]   = MDATAW'($urandom_range(0, DEPTH - 1));
                    dv[i]   = NUBITS'($urandom);
                end
                bus.addr[i*MDATAW +: MDATAW]  = av[i];
                bus.wdata[i*NUBITS +: NUBITS] = dv[i];
            end
            bus.req = pend;
            bus.we  = wv;
            @(negedge clk);
            g  = pick(pend, m_ptr);
            eg = '0;
            if (g >= 0) eg[g] = 1'b1;
            n_chk++; if (bus.gnt !== eg) $display("FAIL rnd_gnt[%0d] got=%b exp=%b", c, bus.gnt, eg); else n_pass++;
            n_chk++; if (bus.rvalid !== m_rv) $display("FAIL rnd_rvalid[%0d] got=%b exp=%b", c, bus.rvalid, m_rv); else n_pass++;
            if (m_rv != '0) begin
                n_chk++; if (bus.rdata !== m_rd) $display("FAIL rnd_rdata[%0d] got=%h exp=%h", c, bus.rdata, m_rd); else n_pass++;
            end
            if (g >= 0) begin
                n_chk++; if (bus.mem_wr !== wv[g]) $display("FAIL rnd_wr[%0d] got=%b exp=%b", c, bus.mem_wr, wv[g]); else n_pass++;
                n_chk++; if (bus.mem_addr_r !== av[g]) $display("FAIL rnd_addr[%0d] got=%0d exp=%0d", c, bus.mem_addr_r, av[g]); else n_pass++;
                if (wv[g]) begin
                    n_chk++; if (bus.mem_data_in !== dv[g]) $display("FAIL rnd_wdata[%0d] got=%h exp=%h", c, bus.mem_data_in, dv[g]); else n_pass++;
                end
                n_chk++; if (waitc[g] > NREQ - 1) $display("FAIL rnd_starve[%0d] got=%0d exp<=%0d", c, waitc[g], NREQ - 1); else n_pass++;
            end else begin
                n_chk++; if (bus.mem_wr !== 1'b0) $display("FAIL rnd_idle_wr[%0d] got=%b exp=0", c, bus.mem_wr); else n_pass++;
            end
            model_step(g);
            for (int i = 0; i < NREQ; i++) begin
                if (i == g) begin
                    pend[i]  = 1'b0;
                    waitc[i] = 0;
                end else if (pend[i]) waitc[i]++;
            end
            tick();
        end
        drive(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
    endtask

`ifdef MEM_ARB_LOCK_EN
    task automatic test_lock();
        apply_reset();
        drive(2'b11, 2'b11, 6'd1, 6'd2, 16'h0, 16'h0);
        bus.lock = 2'b01;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_chk++; if (bus.gnt !== 2'b01) $display("FAIL lock_hold[%0d] got=%b exp=01", c, bus.gnt); else n_pass++;
            tick();
        end
        bus.lock = 2'b00;
        @(negedge clk);
        n_chk++; if (bus.gnt !== 2'b10) $display("FAIL lock_release got=%b exp=10", bus.gnt); else n_pass++;
        tick();
        drive(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
    endtask
`endif

    initial begin
        rst = 1'b1;
        drive(2'b00, 2'b00, 6'd0, 6'd0, 16'h0, 16'h0);
`ifdef MEM_ARB_LOCK_EN
        bus.lock = '0;
`endif
        for (int i = 0; i < DEPTH; i++) pre_img[i] = 16'h0;
        #2;
        test_reset();
        test_contention();
        test_read_latency();
        test_write_then_read();
        test_reset_mid_read();
        test_idle();
        test_back_to_back();
        test_random();
`ifdef MEM_ARB_LOCK_EN
        test_lock();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
